// File: rtl/banco_registros_param_if.sv
// Bus bundle for banco_registros_param: one write port plus two read ports (A, B).
// The master side drives requests; the slave side is the register bank.
interface banco_registros_param_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 16
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned NL = DATA_W / 8;
    localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              wr_size;
    logic [LW-1:0]     wr_lane;
    logic [DATA_W-1:0] wr_data;
    logic              inj_par;
    logic              wr_err;

    logic              rd_req_a;
    logic [AW-1:0]     rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              par_err_a;

    logic              rd_req_b;
    logic [AW-1:0]     rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              par_err_b;

    modport master (
        output wr_en, wr_addr, wr_size, wr_lane, wr_data, inj_par,
        output rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
        input  wr_err, rd_data_a, rd_valid_a, par_err_a, rd_data_b, rd_valid_b, par_err_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_size, wr_lane, wr_data, inj_par,
        input  rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
        output wr_err, rd_data_a, rd_valid_a, par_err_a, rd_data_b, rd_valid_b, par_err_b
    );
endinterface

// File: rtl/banco_registros_param.sv
// Register bank: 1 write port (word or byte-lane), 2 registered read ports with write forwarding.
// Optional per-lane even parity when BANCO_REG_PARITY_EN is defined.
module banco_registros_param #(
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned NUM_BYTE_REGS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    banco_registros_param_if.slave bus
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned NL = DATA_W / 8;
    localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wr_legal_c;
    logic [NL-1:0]     lane_en_c;
    logic [DATA_W-1:0] wr_word_c;

    logic [AW-1:0]     raddr_c [2];
    logic [DATA_W-1:0] rdata_c [2];
    logic [1:0]        perr_c;

    assign raddr_c[0] = bus.rd_addr_a;
    assign raddr_c[1] = bus.rd_addr_b;

`ifdef BANCO_REG_PARITY_EN
    logic [NL-1:0] par_q [NUM_REGS];
    logic [NL-1:0] wr_par_c;
    logic [NL-1:0] rpar_c [2];
`else
    logic unused_inj_c;
    assign unused_inj_c = bus.inj_par;
`endif

    // Write legality, lane enables and the post-write (lane-merged) word
    always_comb begin
        wr_legal_c = bus.wr_en;
        if (32'(bus.wr_addr) >= NUM_REGS)
            wr_legal_c = 1'b0;
        if (!bus.wr_size &&
            ((32'(bus.wr_addr) >= NUM_BYTE_REGS) || (32'(bus.wr_lane) >= NL)))
            wr_legal_c = 1'b0;

        lane_en_c = '0;
        for (int l = 0; l < NL; l++)
            if (bus.wr_size || (LW'(l) == bus.wr_lane))
                lane_en_c[l] = 1'b1;

        wr_word_c = regs[bus.wr_addr];
        for (int l = 0; l < NL; l++)
            if (lane_en_c[l])
                wr_word_c[l*8 +: 8] = bus.wr_size ? bus.wr_data[l*8 +: 8] : bus.wr_data[7:0];

`ifdef BANCO_REG_PARITY_EN
        wr_par_c = par_q[bus.wr_addr];
        for (int l = 0; l < NL; l++)
            if (lane_en_c[l])
                wr_par_c[l] = (^wr_word_c[l*8 +: 8]) ^ bus.inj_par;
`endif
    end

    // Read data per port; a same-address legal write is forwarded
    always_comb begin
        rdata_c = '{default: '0};
        perr_c  = '0;
`ifdef BANCO_REG_PARITY_EN
        rpar_c  = '{default: '0};
`endif
        for (int p = 0; p < 2; p++) begin
            if (32'(raddr_c[p]) < NUM_REGS) begin
                if (wr_legal_c && (bus.wr_addr == raddr_c[p])) begin
                    rdata_c[p] = wr_word_c;
`ifdef BANCO_REG_PARITY_EN
                    rpar_c[p]  = wr_par_c;
`endif
                end else begin
                    rdata_c[p] = regs[raddr_c[p]];
`ifdef BANCO_REG_PARITY_EN
                    rpar_c[p]  = par_q[raddr_c[p]];
`endif
                end
`ifdef BANCO_REG_PARITY_EN
                for (int l = 0; l < NL; l++)
                    if ((^rdata_c[p][l*8 +: 8]) != rpar_c[p][l])
                        perr_c[p] = 1'b1;
`endif
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]  <= '0;
`ifdef BANCO_REG_PARITY_EN
                par_q[i] <= '0;
`endif
            end
            bus.wr_err     <= 1'b0;
            bus.rd_data_a  <= '0;
            bus.rd_valid_a <= 1'b0;
            bus.par_err_a  <= 1'b0;
            bus.rd_data_b  <= '0;
            bus.rd_valid_b <= 1'b0;
            bus.par_err_b  <= 1'b0;
        end else begin
            bus.wr_err <= bus.wr_en && !wr_legal_c;
            if (wr_legal_c) begin
                regs[bus.wr_addr]  <= wr_word_c;
`ifdef BANCO_REG_PARITY_EN
                par_q[bus.wr_addr] <= wr_par_c;
`endif
            end

            bus.rd_valid_a <= bus.rd_req_a;
            bus.par_err_a  <= bus.rd_req_a && perr_c[0];
            if (bus.rd_req_a)
                bus.rd_data_a <= rdata_c[0];

            bus.rd_valid_b <= bus.rd_req_b;
            bus.par_err_b  <= bus.rd_req_b && perr_c[1];
            if (bus.rd_req_b)
                bus.rd_data_b <= rdata_c[1];
        end
    end
endmodule

// File: tb/tb_banco_registros_param.sv
// Directed table-driven bench for banco_registros_param (8 x 16 bit, 3 byte-writable regs),
// plus hand sequences for asynchronous reset in the middle of a read/error cycle.
module tb_banco_registros_param;
    localparam int unsigned NUM_REGS      = 8;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned NUM_BYTE_REGS = 3;
`ifdef BANCO_REG_PARITY_EN
    localparam bit P = 1'b1;
`else
    localparam bit P = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    banco_registros_param_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) bus ();

    banco_registros_param #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .NUM_BYTE_REGS(NUM_BYTE_REGS)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic        we;  logic [2:0] wa; logic ws; logic wl; logic [15:0] wd; logic ip;
        logic        qa;  logic [2:0] aa; logic qb; logic [2:0] ab;
        logic        err;
        logic        va;  logic [15:0] da; logic pa;
        logic        vb;  logic [15:0] db; logic pb;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic we, input logic [2:0] wa, input logic ws, input logic wl,
        input logic [15:0] wd, input logic ip,
        input logic qa, input logic [2:0] aa, input logic qb, input logic [2:0] ab,
        input logic err,
        input logic va, input logic [15:0] da, input logic pa,
        input logic vb, input logic [15:0] db, input logic pb);
        vec_t v;
        v.we = we; v.wa = wa; v.ws = ws; v.wl = wl; v.wd = wd; v.ip = ip;
        v.qa = qa; v.aa = aa; v.qb = qb; v.ab = ab; v.err = err;
        v.va = va; v.da = da; v.pa = pa; v.vb = vb; v.db = db; v.pb = pb;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wr_en = v.we; bus.wr_addr = v.wa; bus.wr_size = v.ws; bus.wr_lane = v.wl;
        bus.wr_data = v.wd; bus.inj_par = v.ip;
        bus.rd_req_a = v.qa; bus.rd_addr_a = v.aa; bus.rd_req_b = v.qb; bus.rd_addr_b = v.ab;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v);
        @(posedge clk);
        #1;
        chk("wr_err",     idx, 32'(bus.wr_err),     32'(v.err));
        chk("rd_valid_a", idx, 32'(bus.rd_valid_a), 32'(v.va));
        chk("rd_data_a",  idx, 32'(bus.rd_data_a),  32'(v.da));
        chk("par_err_a",  idx, 32'(bus.par_err_a),  32'(v.pa));
        chk("rd_valid_b", idx, 32'(bus.rd_valid_b), 32'(v.vb));
        chk("rd_data_b",  idx, 32'(bus.rd_data_b),  32'(v.db));
        chk("par_err_b",  idx, 32'(bus.par_err_b),  32'(v.pb));
    endtask

    task automatic chk_cleared(input int idx);
        chk("rst_wr_err",  idx, 32'(bus.wr_err),     32'd0);
        chk("rst_valid_a", idx, 32'(bus.rd_valid_a), 32'd0);
        chk("rst_data_a",  idx, 32'(bus.rd_data_a),  32'd0);
        chk("rst_par_a",   idx, 32'(bus.par_err_a),  32'd0);
        chk("rst_valid_b", idx, 32'(bus.rd_valid_b), 32'd0);
        chk("rst_data_b",  idx, 32'(bus.rd_data_b),  32'd0);
        chk("rst_par_b",   idx, 32'(bus.par_err_b),  32'd0);
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,16'h0,0, 0,0,0,0, 0, 0,16'h0,0, 0,16'h0,0);
        drive(idle);

        //        we wa ws wl wd       ip qa aa qb ab  err va da       pa vb db       pb
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 0,0,0,0, 0, 0,16'h0000,0, 0,16'h0000,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,5,0,0, 0, 1,16'h0000,0, 0,16'h0000,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 0,0,0,0, 0, 0,16'h0000,0, 0,16'h0000,0));
        vecs.push_back(mk(1,4,1,0,16'hBEEF,0, 0,0,0,0, 0, 0,16'h0000,0, 0,16'h0000,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,4,1,4, 0, 1,16'hBEEF,0, 1,16'hBEEF,0));
        vecs.push_back(mk(1,1,1,0,16'h1234,0, 0,0,0,0, 0, 0,16'hBEEF,0, 0,16'hBEEF,0));
        vecs.push_back(mk(1,1,0,1,16'h00A5,0, 1,1,0,0, 0, 1,16'hA534,0, 0,16'hBEEF,0));
        vecs.push_back(mk(1,1,0,0,16'h0077,0, 0,0,1,1, 0, 0,16'hA534,0, 1,16'hA577,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,1,0,0, 0, 1,16'hA577,0, 0,16'hA577,0));
        vecs.push_back(mk(1,6,1,0,16'h5555,0, 0,0,0,0, 0, 0,16'hA577,0, 0,16'hA577,0));
        vecs.push_back(mk(1,6,0,0,16'h0011,0, 0,0,0,0, 1, 0,16'hA577,0, 0,16'hA577,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 0,0,1,6, 0, 0,16'hA577,0, 1,16'h5555,0));
        vecs.push_back(mk(1,3,0,0,16'h00AA,0, 0,0,0,0, 1, 0,16'hA577,0, 0,16'h5555,0));
        vecs.push_back(mk(0,4,1,0,16'hFFFF,0, 1,3,0,0, 0, 1,16'h0000,0, 0,16'h5555,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,4,1,2, 0, 1,16'hBEEF,0, 1,16'h0000,0));
        vecs.push_back(mk(1,2,0,1,16'h1244,0, 0,0,1,2, 0, 0,16'hBEEF,0, 1,16'h4400,0));
        vecs.push_back(mk(1,3,1,0,16'h00FF,1, 0,0,0,0, 0, 0,16'hBEEF,0, 0,16'h4400,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,3,0,0, 0, 1,16'h00FF,P, 0,16'h4400,0));
        vecs.push_back(mk(1,5,1,0,16'h0101,1, 1,5,1,5, 0, 1,16'h0101,P, 1,16'h0101,P));
        vecs.push_back(mk(1,0,0,0,16'h00C3,1, 1,0,0,0, 0, 1,16'h00C3,P, 0,16'h0101,0));
        vecs.push_back(mk(1,3,1,0,16'h00FF,0, 0,0,1,3, 0, 0,16'h00C3,0, 1,16'h00FF,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,3,1,5, 0, 1,16'h00FF,0, 1,16'h0101,P));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,7,1,6, 0, 1,16'h0000,0, 1,16'h5555,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,0, 1,6,0,0, 0, 1,16'h5555,0, 0,16'h5555,0));

        #12;
        chk_cleared(0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i + 1);

        // Forwarded read on both ports, then async reset mid-cycle drops valid and data
        apply(mk(1,2,1,0,16'hCAFE,0, 1,2,1,2, 0, 1,16'hCAFE,0, 1,16'hCAFE,0), 100);
        #2;
        reset = 1'b0;
        #1;
        chk_cleared(101);
        drive(idle);
        @(negedge clk);
        reset = 1'b1;
        apply(mk(0,0,0,0,16'h0000,0, 1,2,1,4, 0, 1,16'h0000,0, 1,16'h0000,0), 102);

        // Error pulse is also cleared immediately by reset
        apply(mk(1,7,0,0,16'h0011,0, 0,0,0,0, 1, 0,16'h0000,0, 0,16'h0000,0), 103);
        #2;
        reset = 1'b0;
        #1;
        chk_cleared(104);
        drive(idle);
        @(negedge clk);
        reset = 1'b1;
        apply(idle, 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
